// File: rtl/frv_mdu_pkg.sv
// Shared definitions for the MDU sequencer: opcodes, state encoding and op decode.
package frv_mdu_pkg;

  localparam int unsigned OP_W     = 3;
  localparam int unsigned ONEHOT_W = 8;

  localparam logic [OP_W-1:0] MDU_MUL    = 3'd0;
  localparam logic [OP_W-1:0] MDU_MULH   = 3'd1;
  localparam logic [OP_W-1:0] MDU_MULHSU = 3'd2;
  localparam logic [OP_W-1:0] MDU_MULHU  = 3'd3;
  localparam logic [OP_W-1:0] MDU_DIV    = 3'd4;
  localparam logic [OP_W-1:0] MDU_DIVU   = 3'd5;
  localparam logic [OP_W-1:0] MDU_REM    = 3'd6;
  localparam logic [OP_W-1:0] MDU_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } mdu_state_e;

  // funct3 opcode to the MDU's one-hot op lines
  function automatic logic [ONEHOT_W-1:0] op_onehot(input logic [OP_W-1:0] op);
    logic [ONEHOT_W-1:0] oh;
    oh = '0;
    case (op)
      MDU_MUL:    oh = 8'h01;
      MDU_MULH:   oh = 8'h02;
      MDU_MULHSU: oh = 8'h04;
      MDU_MULHU:  oh = 8'h08;
      MDU_DIV:    oh = 8'h10;
      MDU_DIVU:   oh = 8'h20;
      MDU_REM:    oh = 8'h40;
      MDU_REMU:   oh = 8'h80;
      default:    oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/frv_mdu_rcache.sv
// Single-entry result cache keyed on {op, rs1, rs2}; collapses to a constant miss when disabled.
module frv_mdu_rcache
  import frv_mdu_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          CACHE_EN = 1'b1
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            wr_en,
  input  logic [OP_W-1:0] wr_op,
  input  logic [XLEN-1:0] wr_rs1,
  input  logic [XLEN-1:0] wr_rs2,
  input  logic [XLEN-1:0] wr_data,
  input  logic [OP_W-1:0] lk_op,
  input  logic [XLEN-1:0] lk_rs1,
  input  logic [XLEN-1:0] lk_rs2,
  output logic            hit,
  output logic [XLEN-1:0] rd_data
);

  localparam int unsigned TAG_W = OP_W + 2 * XLEN;

  generate
    if (CACHE_EN) begin : g_cache
      logic             valid_q;
      logic [TAG_W-1:0] tag_q;
      logic [XLEN-1:0]  data_q;

      always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
          valid_q <= 1'b0;
          tag_q   <= '0;
          data_q  <= '0;
        end else if (wr_en) begin
          valid_q <= 1'b1;
          tag_q   <= {wr_op, wr_rs1, wr_rs2};
          data_q  <= wr_data;
        end
      end

      assign hit     = valid_q && (tag_q == {lk_op, lk_rs1, lk_rs2});
      assign rd_data = data_q;
    end else begin : g_none
      assign hit     = 1'b0;
      assign rd_data = '0;
    end
  endgenerate

endmodule

// File: rtl/frv_mdu_ctrl.sv
// Execute-stage sequencer for frv_mdu: request/response handshakes, MDU drive,
// post-result flush pulse and an optional repeat-result cache.
module frv_mdu_ctrl
  import frv_mdu_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          CACHE_EN = 1'b1
) (
  input  logic                g_clk,
  input  logic                g_resetn,
  output logic                g_clk_req,
  input  logic                flush,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [OP_W-1:0]     req_op,
  input  logic [XLEN-1:0]     req_rs1,
  input  logic [XLEN-1:0]     req_rs2,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [XLEN-1:0]     rsp_rd,
  output logic                mdu_valid,
  output logic                mdu_flush,
  output logic [ONEHOT_W-1:0] mdu_op,
  output logic [XLEN-1:0]     mdu_rs1,
  output logic [XLEN-1:0]     mdu_rs2,
  input  logic                mdu_ready,
  input  logic [XLEN-1:0]     mdu_rd
);

  mdu_state_e          state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [XLEN-1:0]     rs1_d, rs2_d, rsp_rd_d;
  logic                rsp_valid_d, mdu_valid_d;
  logic [ONEHOT_W-1:0] mdu_op_d;
  logic                hit_flag_q, hit_flag_d;
  logic                resp_first_q, resp_first_d;
  logic                cache_hit, cache_wr;
  logic [XLEN-1:0]     cache_data;

  frv_mdu_rcache #(
    .XLEN     (XLEN),
    .CACHE_EN (CACHE_EN)
  ) u_rcache (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .wr_en    (cache_wr),
    .wr_op    (op_q),
    .wr_rs1   (mdu_rs1),
    .wr_rs2   (mdu_rs2),
    .wr_data  (mdu_rd),
    .lk_op    (req_op),
    .lk_rs1   (req_rs1),
    .lk_rs2   (req_rs2),
    .hit      (cache_hit),
    .rd_data  (cache_data)
  );

  // Next state; flush overrides everything and discards any result in flight
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rs1_d        = mdu_rs1;
    rs2_d        = mdu_rs2;
    rsp_rd_d     = rsp_rd;
    hit_flag_d   = hit_flag_q;
    resp_first_d = 1'b0;
    cache_wr     = 1'b0;

    if (flush) begin
      state_d    = ST_IDLE;
      hit_flag_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_d  = req_op;
            rs1_d = req_rs1;
            rs2_d = req_rs2;
            if (cache_hit) begin
              rsp_rd_d   = cache_data;
              hit_flag_d = 1'b1;
              state_d    = ST_RESP;
            end else begin
              hit_flag_d = 1'b0;
              state_d    = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (mdu_ready) begin
            rsp_rd_d     = mdu_rd;
            cache_wr     = 1'b1;
            resp_first_d = 1'b1;
            state_d      = ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_d    = ST_IDLE;
            hit_flag_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    rsp_valid_d = (state_d == ST_RESP);
    mdu_valid_d = (state_d == ST_RUN);
    mdu_op_d    = (state_d == ST_RUN) ? op_onehot(op_d) : '0;
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      mdu_rs1      <= '0;
      mdu_rs2      <= '0;
      rsp_rd       <= '0;
      rsp_valid    <= 1'b0;
      mdu_valid    <= 1'b0;
      mdu_op       <= '0;
      hit_flag_q   <= 1'b0;
      resp_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      mdu_rs1      <= rs1_d;
      mdu_rs2      <= rs2_d;
      rsp_rd       <= rsp_rd_d;
      rsp_valid    <= rsp_valid_d;
      mdu_valid    <= mdu_valid_d;
      mdu_op       <= mdu_op_d;
      hit_flag_q   <= hit_flag_d;
      resp_first_q <= resp_first_d;
    end
  end

  // MDU done is sticky, so clear it once per computed result and whenever we abandon or reset
  assign mdu_flush = !g_resetn || flush ||
                     ((state_q == ST_RESP) && resp_first_q && !hit_flag_q);
  assign req_ready = (state_q == ST_IDLE) && !flush;
  assign g_clk_req = (state_q != ST_IDLE) || req_valid || flush;

endmodule

// File: tb/tb_frv_mdu_ctrl.sv
// Directed bench for frv_mdu_ctrl with a behavioural fixed-latency MDU attached.
module tb_frv_mdu_ctrl;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned MDU_LAT = 4;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        g_clk_req;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [31:0] req_rs1 = '0;
  logic [31:0] req_rs2 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rd;
  logic        mdu_valid;
  logic        mdu_flush;
  logic [7:0]  mdu_op;
  logic [31:0] mdu_rs1;
  logic [31:0] mdu_rs2;
  logic        mdu_ready;
  logic [31:0] mdu_rd;

  int passed = 0;
  int total  = 0;

  frv_mdu_ctrl #(.XLEN(XLEN), .CACHE_EN(1'b1)) dut (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .g_clk_req (g_clk_req),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rd    (rsp_rd),
    .mdu_valid (mdu_valid),
    .mdu_flush (mdu_flush),
    .mdu_op    (mdu_op),
    .mdu_rs1   (mdu_rs1),
    .mdu_rs2   (mdu_rs2),
    .mdu_ready (mdu_ready),
    .mdu_rd    (mdu_rd)
  );

  always #5 g_clk = ~g_clk;

  // Behavioural MDU: RISC-V M-extension results, sticky done cleared by mdu_flush
  function automatic logic [31:0] mdu_calc(input logic [7:0] oh, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0] ua, ub, up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (oh)
      8'h01: begin up = ua * ub; return up[31:0]; end
      8'h02: begin sp = sa * sb; return sp[63:32]; end
      8'h04: begin sp = sa * $signed(ub); return sp[63:32]; end
      8'h08: begin up = ua * ub; return up[63:32]; end
      8'h10: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return 32'($signed(a) / $signed(b));
      end
      8'h20: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
      8'h40: begin
        if (b == 32'd0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return 32'($signed(a) % $signed(b));
      end
      8'h80: return (b == 32'd0) ? a : a % b;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  logic        mdl_done = 1'b0;
  int unsigned mdl_cnt  = 0;
  logic [31:0] mdl_rd   = '0;

  always @(posedge g_clk) begin
    if (mdu_flush) begin
      mdl_done <= 1'b0;
      mdl_cnt  <= 0;
    end else if (mdu_valid && !mdl_done) begin
      if (mdl_cnt == MDU_LAT - 1) begin
        mdl_done <= 1'b1;
        mdl_rd   <= mdu_calc(mdu_op, mdu_rs1, mdu_rs2);
      end else begin
        mdl_cnt <= mdl_cnt + 1;
      end
    end
  end

  assign mdu_ready = mdl_done;
  assign mdu_rd    = mdl_rd;

  // Transaction drivers; all sampling happens 2 time units after the rising edge
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!req_ready && n < 20) begin @(posedge g_clk); #2; n++; end
    total++;
    if (req_ready !== 1'b1) $display("FAIL send_req_ready: got %b want 1", req_ready); else passed++;
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b;
    @(posedge g_clk); #1;
    req_valid = 1'b0; #1;
  endtask

  task automatic wait_rsp(input logic [7:0] exp_oh, output int lat, output bit mseen,
                          output bit op_ok, output logic [31:0] rd);
    lat = 1; mseen = 1'b0; op_ok = 1'b1;
    while (!rsp_valid && lat < 64) begin
      if (mdu_valid) begin
        mseen = 1'b1;
        if (mdu_op !== exp_oh) op_ok = 1'b0;
      end
      @(posedge g_clk); #2; lat++;
    end
    rd = rsp_rd;
    total++;
    if (rsp_valid !== 1'b1) $display("FAIL rsp_timeout: rsp_valid=%b want 1", rsp_valid); else passed++;
  endtask

  task automatic consume(input int hold, output bit fl_first, output int fl_extra, output bit stable_ok);
    logic [31:0] rd0;
    fl_first = mdu_flush; rd0 = rsp_rd; fl_extra = 0; stable_ok = 1'b1;
    repeat (hold) begin
      @(posedge g_clk); #2;
      if (rsp_valid !== 1'b1 || rsp_rd !== rd0 || req_ready !== 1'b0 || mdu_valid !== 1'b0) stable_ok = 1'b0;
      if (mdu_flush) fl_extra++;
    end
    rsp_ready = 1'b1;
    @(posedge g_clk); #1;
    rsp_ready = 1'b0; #1;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [7:0] oh, input int hold, output logic [31:0] rd,
                        output int lat, output bit mseen, output bit op_ok, output bit fl_first,
                        output int fl_extra, output bit stable_ok);
    send(op, a, b);
    wait_rsp(oh, lat, mseen, op_ok, rd);
    consume(hold, fl_first, fl_extra, stable_ok);
  endtask

  task automatic test_reset;
    g_resetn = 1'b0;
    repeat (3) @(posedge g_clk);
    #2;
    total++; if (mdu_flush !== 1'b1) $display("FAIL reset_mdu_flush: got %b want 1", mdu_flush); else passed++;
    total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else passed++;
    total++; if (rsp_rd !== 32'd0) $display("FAIL reset_rsp_rd: got %h want 0", rsp_rd); else passed++;
    total++; if (mdu_valid !== 1'b0) $display("FAIL reset_mdu_valid: got %b want 0", mdu_valid); else passed++;
    total++; if (mdu_op !== 8'h00) $display("FAIL reset_mdu_op: got %h want 00", mdu_op); else passed++;
    total++; if ({mdu_rs1, mdu_rs2} !== 64'd0) $display("FAIL reset_mdu_rs: got %h want 0", {mdu_rs1, mdu_rs2}); else passed++;
    g_resetn = 1'b1;
    @(posedge g_clk); #2;
    total++; if (req_ready !== 1'b1) $display("FAIL idle_req_ready: got %b want 1", req_ready); else passed++;
    total++; if (mdu_flush !== 1'b0) $display("FAIL idle_mdu_flush: got %b want 0", mdu_flush); else passed++;
    total++; if (g_clk_req !== 1'b0) $display("FAIL idle_clk_req: got %b want 0", g_clk_req); else passed++;
  endtask

  task automatic test_basic_mul;
    logic [31:0] rd; int lat, fe; bit ms, ok, ff, st;
    run_op(3'd0, 32'd6, 32'd7, 8'h01, 0, rd, lat, ms, ok, ff, fe, st);
    total++; if (rd !== 32'd42) $display("FAIL mul_rd: got %h want 2a", rd); else passed++;
    total++; if (lat != 6) $display("FAIL mul_latency: got %0d want 6", lat); else passed++;
    total++; if (!(ms && ok)) $display("FAIL mul_mdu_op: seen=%b op_ok=%b want 1 1", ms, ok); else passed++;
    total++; if (ff !== 1'b1) $display("FAIL mul_flush_pulse: got %b want 1", ff); else passed++;
    total++; if (mdu_flush !== 1'b0) $display("FAIL mul_flush_after: got %b want 0", mdu_flush); else passed++;
  endtask

  task automatic test_high_half_div0;
    logic [2:0]  t_op [6];
    logic [31:0] t_a [6];
    logic [31:0] t_b [6];
    logic [31:0] t_e [6];
    logic [7:0]  t_oh [6];
    logic [31:0] rd; int lat, fe; bit ms, ok, ff, st;
    t_op = '{3'd1, 3'd5, 3'd6, 3'd4, 3'd2, 3'd7};
    t_a  = '{32'h80000000, 32'd5, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'd10};
    t_b  = '{32'h80000000, 32'd0, 32'd0, 32'd2, 32'hFFFFFFFF, 32'd3};
    t_e  = '{32'h40000000, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd1};
    t_oh = '{8'h02, 8'h20, 8'h40, 8'h10, 8'h04, 8'h80};
    for (int i = 0; i < 6; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], t_oh[i], 0, rd, lat, ms, ok, ff, fe, st);
      total++; if (rd !== t_e[i]) $display("FAIL vec%0d_rd: got %h want %h", i, rd, t_e[i]); else passed++;
      total++; if (!(ms && ok && lat == 6)) $display("FAIL vec%0d_run: seen=%b op_ok=%b lat=%0d want 1 1 6", i, ms, ok, lat); else passed++;
    end
  endtask

  task automatic test_cache_hit;
    logic [31:0] rd; int lat, fe; bit ms, ok, ff, st;
    run_op(3'd4, 32'd100, 32'd7, 8'h10, 0, rd, lat, ms, ok, ff, fe, st);
    total++; if (rd !== 32'd14 || lat != 6) $display("FAIL div_miss: rd=%h lat=%0d want e 6", rd, lat); else passed++;
    run_op(3'd4, 32'd100, 32'd7, 8'h10, 0, rd, lat, ms, ok, ff, fe, st);
    total++; if (rd !== 32'd14) $display("FAIL hit_rd: got %h want e", rd); else passed++;
    total++; if (lat != 1) $display("FAIL hit_latency: got %0d want 1", lat); else passed++;
    total++; if (ms !== 1'b0) $display("FAIL hit_mdu_valid: got %b want 0", ms); else passed++;
    total++; if (ff !== 1'b0) $display("FAIL hit_flush_pulse: got %b want 0", ff); else passed++;
    run_op(3'd6, 32'd100, 32'd7, 8'h40, 0, rd, lat, ms, ok, ff, fe, st);
    total++; if (rd !== 32'd2 || lat != 6 || !ms) $display("FAIL rem_miss: rd=%h lat=%0d seen=%b want 2 6 1", rd, lat, ms); else passed++;
  endtask

  task automatic test_backpressure;
    logic [31:0] rd; int lat, fe; bit ms, ok, ff, st;
    run_op(3'd3, 32'hFFFFFFFF, 32'd2, 8'h08, 5, rd, lat, ms, ok, ff, fe, st);
    total++; if (rd !== 32'd1) $display("FAIL bp_rd: got %h want 1", rd); else passed++;
    total++; if (st !== 1'b1) $display("FAIL bp_stable: got %b want 1", st); else passed++;
    total++; if (ff !== 1'b1 || fe != 0) $display("FAIL bp_flush_once: first=%b extra=%0d want 1 0", ff, fe); else passed++;
    total++; if (req_ready !== 1'b1) $display("FAIL bp_req_ready_after: got %b want 1", req_ready); else passed++;
  endtask

  task automatic test_flush_run;
    logic [31:0] rd; int lat, fe; bit ms, ok, ff, st;
    send(3'd5, 32'd20, 32'd3);
    repeat (2) begin @(posedge g_clk); #2; end
    flush = 1'b1; #1;
    total++; if (mdu_flush !== 1'b1) $display("FAIL flush_mdu_flush: got %b want 1", mdu_flush); else passed++;
    @(posedge g_clk); #1;
    flush = 1'b0; #1;
    total++; if (req_ready !== 1'b1 || mdu_valid !== 1'b0) $display("FAIL flush_idle: req_ready=%b mdu_valid=%b want 1 0", req_ready, mdu_valid); else passed++;
    repeat (MDU_LAT + 2) @(posedge g_clk);
    #2;
    total++; if (rsp_valid !== 1'b0) $display("FAIL flush_no_rsp: got %b want 0", rsp_valid); else passed++;
    run_op(3'd0, 32'd3, 32'd3, 8'h01, 0, rd, lat, ms, ok, ff, fe, st);
    total++; if (rd !== 32'd9 || lat != 6) $display("FAIL after_flush_mul: rd=%h lat=%0d want 9 6", rd, lat); else passed++;
  endtask

  task automatic test_flush_ready;
    logic [31:0] rd; int lat, fe; bit ms, ok, ff, st;
    int n = 0;
    send(3'd5, 32'd20, 32'd3);
    while (!mdu_ready && n < 20) begin @(posedge g_clk); #2; n++; end
    total++; if (mdu_ready !== 1'b1) $display("FAIL wait_mdu_ready: got %b want 1", mdu_ready); else passed++;
    flush = 1'b1;
    @(posedge g_clk); #1;
    flush = 1'b0; #1;
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL flush_ready_drop: rsp_valid=%b req_ready=%b want 0 1", rsp_valid, req_ready); else passed++;
    run_op(3'd5, 32'd20, 32'd3, 8'h20, 0, rd, lat, ms, ok, ff, fe, st);
    total++; if (rd !== 32'd6 || lat != 6 || !ms) $display("FAIL flushed_repeat_miss: rd=%h lat=%0d seen=%b want 6 6 1", rd, lat, ms); else passed++;
  endtask

  task automatic test_reset_resp;
    logic [31:0] rd; int lat, fe; bit ms, ok, ff, st;
    run_op(3'd0, 32'd5, 32'd5, 8'h01, 0, rd, lat, ms, ok, ff, fe, st);
    total++; if (rd !== 32'd25) $display("FAIL rr_first_rd: got %h want 19", rd); else passed++;
    send(3'd0, 32'd5, 32'd5);
    wait_rsp(8'h01, lat, ms, ok, rd);
    g_resetn = 1'b0; #1;
    total++; if (mdu_flush !== 1'b1) $display("FAIL rr_mdu_flush: got %b want 1", mdu_flush); else passed++;
    @(posedge g_clk); #1;
    g_resetn = 1'b1; #1;
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL rr_idle: rsp_valid=%b req_ready=%b want 0 1", rsp_valid, req_ready); else passed++;
    total++; if (rsp_rd !== 32'd0) $display("FAIL rr_rsp_rd: got %h want 0", rsp_rd); else passed++;
    run_op(3'd0, 32'd5, 32'd5, 8'h01, 0, rd, lat, ms, ok, ff, fe, st);
    total++; if (rd !== 32'd25 || lat != 6 || !ms) $display("FAIL rr_cache_cleared: rd=%h lat=%0d seen=%b want 19 6 1", rd, lat, ms); else passed++;
  endtask

  initial begin
    test_reset;
    test_basic_mul;
    test_high_half_div0;
    test_cache_hit;
    test_backpressure;
    test_flush_run;
    test_flush_ready;
    test_reset_resp;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

endmodule

// File: doc/frv_mdu_ctrl.md
Name: frv_mdu_ctrl

Overview:
- Sequencer between the execute stage and the multiply/divide unit (frv_mdu).
- Accepts one operation per request handshake and registers opcode and operands.
- Drives the MDU's one-hot op lines, valid and flush, holding them stable until the MDU reports ready.
- Captures the result and presents it on a valid/ready response port. After every completed operation it pulses the MDU flush so the MDU's sticky done state is cleared.
- An optional single-entry result cache answers an exact repeat of the previous operation without starting the MDU.

Parameters:
- XLEN, 32, datapath width.
- CACHE_EN, 1, 1 enables the single-entry repeat-result cache; 0 removes it (every request runs the MDU).

Ports:
- g_clk  in  1  clock.
- g_resetn  in  1  reset; synchronous, active-low.
- g_clk_req  out  1  clock request: high when state!=IDLE, or req_valid, or flush.
- flush  in  1  pipeline flush; abandons any operation in progress.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid&&req_ready.
- req_op  in  3  opcode, encoded as RISC-V funct3: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
- req_rs1  in  XLEN  operand 1.
- req_rs2  in  XLEN  operand 2.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumed when rsp_valid&&rsp_ready.
- rsp_rd  out  XLEN  result.
- mdu_valid  out  1  drives the MDU valid input.
- mdu_flush  out  1  drives the MDU flush input.
- mdu_op  out  8  one-hot MDU op lines, bit n corresponds to req_op==n.
- mdu_rs1  out  XLEN  registered operand 1.
- mdu_rs2  out  XLEN  registered operand 2.
- mdu_ready  in  1  MDU finished.
- mdu_rd  in  XLEN  MDU result.

Behaviour:
- Reset values: state=IDLE, rsp_valid=0, rsp_rd=0, mdu_valid=0, mdu_op=0, mdu_rs1=0, mdu_rs2=0, cache invalid.
- mdu_flush = flush || (state==RESP && resp_first && !hit_flag). It is high during reset.
- req_ready = (state==IDLE) && !flush.
- There is no request/response overlap; at least one idle cycle separates operations.
- IDLE:
  - On accept, latch op, rs1 and rs2.
  - If CACHE_EN, cache valid, and {op,rs1,rs2} equal the cache tag: load rsp_rd from the cache, set hit_flag, go to RESP.
  - Otherwise go to RUN.
- RUN:
  - mdu_valid=1; mdu_op and mdu operands come from the latched registers and are held constant.
  - When mdu_ready=1: capture mdu_rd into rsp_rd, write the cache (tag and data), go to RESP.
  - mdu_ready is only sampled in RUN.
- RESP:
  - rsp_valid=1; mdu_valid=0 and mdu_op=0.
  - On the first RESP cycle after RUN, mdu_flush pulses for exactly one cycle. It does not pulse after a cache hit.
  - rsp_rd is held stable while rsp_ready=0.
  - On rsp_valid&&rsp_ready, go to IDLE.
- Latency, accept to rsp_valid:
  - Cache miss: MDU cycles (cycles in RUN until mdu_ready) + 1.
  - Cache hit: exactly 1 cycle.
- Flush:
  - Highest priority in every state: next state=IDLE, no response is produced, and an in-flight result is discarded.
  - mdu_flush follows flush combinationally in the same cycle.
  - Flush does not invalidate the cache, since the cache is keyed on operand values; only reset invalidates it.
  - A flush coinciding with mdu_ready in RUN discards the result and does not write the cache.
  - A flush coinciding with the response handshake: flush wins and the response is treated as not delivered.
- Reset mid-operation: returns to the reset values above.

Decomposition:
- Shared package frv_mdu_pkg:
  - opcode localparams (MUL..REMU).
  - state encoding IDLE/RUN/RESP (2 bits).
  - a function converting the 3-bit opcode to the 8-bit one-hot.
- Sub-module frv_mdu_rcache:
  - single tag+data register, compare and write-enable.
  - tied off when CACHE_EN=0.

Test Plan:
- Basic multiply: MUL rs1=6, rs2=7 with the real frv_mdu attached -> rsp_rd=42; a one-cycle mdu_flush pulse occurs on the first RESP cycle; mdu_op=8'h01 throughout RUN.
- High-half and divide by zero:
  - MULH 0x80000000×0x80000000 -> 0x40000000.
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REM 7 % 0 -> 7.
  - DIV -7/2 -> 0xFFFFFFFD.
- Cache hit: DIV 100/7 -> 14; repeat the identical request -> rsp_valid exactly 1 cycle after accept, rsp_rd=14, mdu_valid never asserted, no mdu_flush pulse. REM 100/7 then misses and returns 2.
- Backpressure: rsp_ready held low for 5 cycles after rsp_valid -> rsp_valid and rsp_rd stable, req_ready=0. When rsp_ready rises, the handshake completes and req_ready=1 on the next cycle.
- Flush mid-RUN: flush on the 3rd RUN cycle of DIVU -> mdu_flush high that cycle, no rsp_valid, IDLE next cycle. A following MUL 3×3 returns 9. Repeating the flushed DIVU misses the cache.
- Reset during RESP with rsp_ready=0: g_resetn low for 1 cycle -> rsp_valid=0, state IDLE, cache invalid (the next identical request runs the MDU).
